// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: round-robin owner of the single SD sector port across NUM_REQ requesters.
// Optional `SD_ARB_WATCHDOG_EN aborts a grant stuck in ISSUE/XFER after WDOG_CYCLES clocks.

module sd_arb_lane (
  input  logic granted,
  input  logic in_xfer,
  input  logic byte_strobe,
  input  logic rd,
  input  logic wr,
  output logic req_byte_strobe,
  output logic pending
);
  assign req_byte_strobe = granted & in_xfer & byte_strobe;
  assign pending         = rd | wr;
endmodule

module sd_sector_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int WDOG_CYCLES = 2000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [32*NUM_REQ-1:0]  req_lba,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [NUM_REQ-1:0]     req_wr,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [NUM_REQ-1:0]     req_byte_strobe,
  output logic [31:0]            sd_lba,
  output logic [NUM_REQ-1:0]     sd_rd,
  output logic [NUM_REQ-1:0]     sd_wr,
  input  logic                   sd_busy,
  input  logic                   sd_done,
  input  logic                   sd_rd_byte_strobe,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   active
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_cfg_check
    $error("sd_sector_arbiter: NUM_REQ must be 1..8 and WDOG_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

  state_t                   state, state_d;
  logic [IW-1:0]            last_grant, last_grant_d;
  logic [IW-1:0]            gidx, gidx_d;
  logic [IW-1:0]            pick;
  logic                     pick_vld;
  logic [NUM_REQ-1:0]       pick_oh;
  logic [NUM_REQ-1:0]       pend;
  logic [NUM_REQ-1:0]       grant_d, sd_rd_d, sd_wr_d, req_busy_d, req_done_d;
  logic [31:0]              sd_lba_d;
  logic [NUM_REQ-1:0][31:0] lba_v;
  logic                     in_xfer;
  int                       j;
  logic [IW-1:0]            jj;

  assign lba_v   = req_lba;
  assign in_xfer = (state == XFER);
  assign active  = (state != IDLE);
  assign pick_oh = NUM_REQ'(1) << pick;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sd_arb_lane u_lane (
      .granted         (grant[i]),
      .in_xfer         (in_xfer),
      .byte_strobe     (sd_rd_byte_strobe),
      .rd              (req_rd[i]),
      .wr              (req_wr[i]),
      .req_byte_strobe (req_byte_strobe[i]),
      .pending         (pend[i])
    );
  end

  // Scan starts one past the last served channel so a finished owner goes to the back.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    j        = 0;
    jj       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(last_grant) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!pick_vld && pend[jj]) begin
        pick_vld = 1'b1;
        pick     = jj;
      end
    end
  end

`ifdef SD_ARB_WATCHDOG_EN
  logic [31:0]        wdog_cnt, wdog_cnt_d;
  logic [NUM_REQ-1:0] req_err_d;
  logic               wdog_hit;

  assign wdog_hit = (wdog_cnt == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      req_err  <= '0;
    end else begin
      wdog_cnt <= wdog_cnt_d;
      req_err  <= req_err_d;
    end
  end
`else
  assign req_err = '0;
`endif

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    gidx_d       = gidx;
    grant_d      = grant;
    sd_lba_d     = sd_lba;
    sd_rd_d      = sd_rd;
    sd_wr_d      = sd_wr;
    req_busy_d   = req_busy;
    req_done_d   = '0;
`ifdef SD_ARB_WATCHDOG_EN
    req_err_d    = '0;
    wdog_cnt_d   = wdog_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d  = ISSUE;
          gidx_d   = pick;
          grant_d  = pick_oh;
          sd_lba_d = lba_v[pick];
          // Read wins a simultaneous rd+wr; the write stays pending for the next grant.
          if (req_rd[pick]) sd_rd_d = pick_oh;
          else              sd_wr_d = pick_oh;
`ifdef SD_ARB_WATCHDOG_EN
          wdog_cnt_d = '0;
`endif
        end
      end
      ISSUE: begin
`ifdef SD_ARB_WATCHDOG_EN
        wdog_cnt_d = wdog_cnt + 32'd1;
`endif
        if (sd_busy) begin
          sd_rd_d    = '0;
          sd_wr_d    = '0;
          req_busy_d = grant;
          state_d    = XFER;
        end
`ifdef SD_ARB_WATCHDOG_EN
        else if (wdog_hit) begin
          sd_rd_d      = '0;
          sd_wr_d      = '0;
          req_busy_d   = '0;
          req_done_d   = grant;
          req_err_d    = grant;
          last_grant_d = gidx;
          state_d      = RELEASE;
        end
`endif
      end
      XFER: begin
`ifdef SD_ARB_WATCHDOG_EN
        wdog_cnt_d = wdog_cnt + 32'd1;
`endif
        if (sd_done) begin
          req_done_d   = grant;
          req_busy_d   = '0;
          last_grant_d = gidx;
          state_d      = RELEASE;
        end
`ifdef SD_ARB_WATCHDOG_EN
        else if (wdog_hit) begin
          req_busy_d   = '0;
          req_done_d   = grant;
          req_err_d    = grant;
          last_grant_d = gidx;
          state_d      = RELEASE;
        end
`endif
      end
      RELEASE: begin
        // Hold off until the controller drops busy so sectors never overlap.
        if (!sd_busy) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      gidx       <= '0;
      grant      <= '0;
      sd_lba     <= '0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      req_busy   <= '0;
      req_done   <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      gidx       <= gidx_d;
      grant      <= grant_d;
      sd_lba     <= sd_lba_d;
      sd_rd      <= sd_rd_d;
      sd_wr      <= sd_wr_d;
      req_busy   <= req_busy_d;
      req_done   <= req_done_d;
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: expected issue/done events are queued by the
// directed stimulus and popped by an independent monitor when the DUT presents them.

module tb_sd_sector_arbiter;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [32*N-1:0] req_lba = '0;
  logic [N-1:0]   req_rd = '0, req_wr = '0;
  logic [N-1:0]   req_busy, req_done, req_err, req_byte_strobe, sd_rd, sd_wr, grant;
  logic [31:0]    sd_lba;
  logic           sd_busy, sd_done, active;
  logic           sd_rd_byte_strobe = 1'b0;

  logic sd_auto = 1'b0, man_busy = 1'b0, man_done = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int   m_st = 0, m_cnt = 0;
  assign sd_busy = sd_auto ? m_busy : man_busy;
  assign sd_done = sd_auto ? m_done : man_done;

  int total = 0, bad = 0;

  typedef struct packed {
    logic         kind;   // 0 = issue, 1 = done
    logic [N-1:0] rd;
    logic [N-1:0] wr;
    logic [31:0]  lba;
    logic [N-1:0] done;
    logic [N-1:0] err;
  } exp_t;
  exp_t q[$];

  logic cnt_en = 1'b0;
  int   scnt [N];

  sd_sector_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
    .req_byte_strobe(req_byte_strobe), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_busy(sd_busy), .sd_done(sd_done), .sd_rd_byte_strobe(sd_rd_byte_strobe),
    .grant(grant), .active(active)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  function automatic exp_t ex_issue(input logic [N-1:0] rd, input logic [N-1:0] wr,
                                    input logic [31:0] lba);
    exp_t e;
    e = '0; e.kind = 1'b0; e.rd = rd; e.wr = wr; e.lba = lba;
    return e;
  endfunction

  function automatic exp_t ex_done(input logic [N-1:0] done, input logic [N-1:0] err);
    exp_t e;
    e = '0; e.kind = 1'b1; e.done = done; e.err = err;
    return e;
  endfunction

  // Monitor: compares each new issue (rising sd_rd|sd_wr) and each done pulse.
  initial begin
    logic [N-1:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = sd_rd | sd_wr;
      if (reset_n && cur != '0 && prev == '0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected: sd_rd=%b sd_wr=%b want no issue", sd_rd, sd_wr);
        end else begin
          e = q.pop_front();
          if (e.kind != 1'b0 || sd_rd != e.rd || sd_wr != e.wr || sd_lba != e.lba ||
              grant != (e.rd | e.wr)) begin
            bad++;
            $display("FAIL issue: kind=0 rd=%b wr=%b lba=%0h grant=%b want kind=%0d rd=%b wr=%b lba=%0h",
                     sd_rd, sd_wr, sd_lba, grant, e.kind, e.rd, e.wr, e.lba);
          end
        end
      end
      if (reset_n && (req_done != '0 || req_err != '0)) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: req_done=%b req_err=%b want none", req_done, req_err);
        end else begin
          e = q.pop_front();
          if (e.kind != 1'b1 || req_done != e.done || req_err != e.err || req_busy != '0) begin
            bad++;
            $display("FAIL done: kind=1 done=%b err=%b busy=%b want kind=%0d done=%b err=%b busy=0",
                     req_done, req_err, req_busy, e.kind, e.done, e.err);
          end
        end
      end
      prev = cur;
    end
  end

  // Simple SD controller: busy one cycle after a request, done after 10 busy cycles.
  initial forever begin
    @(posedge clk); #2;
    if (!sd_auto) begin
      m_st = 0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      case (m_st)
        0: if ((sd_rd | sd_wr) != '0) begin m_busy = 1'b1; m_cnt = 0; m_st = 1; end
        1: begin m_cnt++; if (m_cnt == 10) begin m_done = 1'b1; m_st = 2; end end
        default: begin m_done = 1'b0; m_busy = 1'b0; m_st = 0; end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!cnt_en) scnt[i] = 0;
      else if (req_byte_strobe[i]) scnt[i] = scnt[i] + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_lba(input int ch, input logic [31:0] v);
    req_lba[32*ch +: 32] = v;
  endtask

  task automatic wait_issue(input string nm);
    int n;
    n = 0;
    while ((sd_rd | sd_wr) == '0 && n < 100) begin tick(); n++; end
    if ((sd_rd | sd_wr) == '0) begin
      total++; bad++;
      $display("FAIL %s: no sd_rd/sd_wr after %0d cycles, want an issue", nm, n);
    end
  endtask

  task automatic wait_busy(input string nm, input logic want);
    int n;
    n = 0;
    while ((req_busy != '0) != want && n < 100) begin tick(); n++; end
    if ((req_busy != '0) != want) begin
      total++; bad++;
      $display("FAIL %s: req_busy=%b after %0d cycles, want nonzero=%0d", nm, req_busy, n, want);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (active && n < 400) begin tick(); n++; end
    if (active) begin
      total++; bad++;
      $display("FAIL %s: active=1 after %0d cycles, want 0", nm, n);
    end
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_req_busy", 32'(req_busy), 0);
    chk("rst_req_done", 32'(req_done), 0);
    chk("rst_req_err", 32'(req_err), 0);
    chk("rst_strobe", 32'(req_byte_strobe), 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_active", 32'(active), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single read on channel 0
    set_lba(0, 32'd7);
    q.push_back(ex_issue(5'b00001, 5'b00000, 32'd7));
    req_rd = 5'b00001;
    wait_issue("t1_issue");
    man_busy = 1'b1;
    tick();
    chk("t1_req_busy", 32'(req_busy), 32'b00001);
    chk("t1_sd_rd_drop", 32'(sd_rd), 0);
    req_rd = '0;
    q.push_back(ex_done(5'b00001, 5'b00000));
    man_done = 1'b1;
    tick();
    man_done = 1'b0; man_busy = 1'b0;
    wait_idle("t1_idle");

    // 2: round robin over 0,2,4 with requests held
    do_reset();
    for (int c = 0; c < N; c++) set_lba(c, 32'(100 + c));
    q.push_back(ex_issue(5'b00001, '0, 32'd100)); q.push_back(ex_done(5'b00001, '0));
    q.push_back(ex_issue(5'b00100, '0, 32'd102)); q.push_back(ex_done(5'b00100, '0));
    q.push_back(ex_issue(5'b10000, '0, 32'd104)); q.push_back(ex_done(5'b10000, '0));
    q.push_back(ex_issue(5'b00001, '0, 32'd100)); q.push_back(ex_done(5'b00001, '0));
    q.push_back(ex_issue(5'b00100, '0, 32'd102)); q.push_back(ex_done(5'b00100, '0));
    sd_auto = 1'b1;
    req_rd = 5'b10101;
    n = 0;
    while (q.size() != 0 && n < 400) begin tick(); n++; end
    req_rd = '0;
    chk("t2_left", 32'(q.size()), 0);
    wait_idle("t2_idle");
    sd_auto = 1'b0;
    tick();

    // 3: byte strobes routed only to channel 3 and only in XFER
    set_lba(3, 32'h300);
    q.push_back(ex_issue(5'b01000, '0, 32'h300));
    req_rd = 5'b01000;
    wait_issue("t3_issue");
    cnt_en = 1'b1;
    sd_rd_byte_strobe = 1'b1;
    repeat (3) tick();
    sd_rd_byte_strobe = 1'b0;
    man_busy = 1'b1;
    tick();
    req_rd = '0;
    sd_rd_byte_strobe = 1'b1;
    repeat (512) tick();
    sd_rd_byte_strobe = 1'b0;
    tick();
    for (int i = 0; i < N; i++) chk($sformatf("t3_strobe_cnt%0d", i), 32'(scnt[i]), (i == 3) ? 32'd512 : 32'd0);
    cnt_en = 1'b0;
    q.push_back(ex_done(5'b01000, '0));
    man_done = 1'b1;
    tick();
    man_done = 1'b0; man_busy = 1'b0;
    wait_idle("t3_idle");

    // 4: simultaneous rd+wr on channel 1 -> read first, then write
    set_lba(1, 32'h11);
    q.push_back(ex_issue(5'b00010, '0, 32'h11));       q.push_back(ex_done(5'b00010, '0));
    q.push_back(ex_issue('0, 5'b00010, 32'h11));       q.push_back(ex_done(5'b00010, '0));
    sd_auto = 1'b1;
    req_rd = 5'b00010; req_wr = 5'b00010;
    wait_busy("t4_rd_busy", 1'b1);
    req_rd = '0;
    wait_busy("t4_rd_release", 1'b0);
    wait_busy("t4_wr_busy", 1'b1);
    req_wr = '0;
    wait_idle("t4_idle");
    sd_auto = 1'b0;
    tick();
    chk("t4_left", 32'(q.size()), 0);

    // 5: reset during XFER, then channel 0 wins despite channel 2 pending
    set_lba(2, 32'h22);
    q.push_back(ex_issue(5'b00100, '0, 32'h22));
    req_rd = 5'b00100;
    wait_issue("t5_issue");
    man_busy = 1'b1;
    tick();
    req_rd = '0;
    tick();
    chk("t5_in_xfer", 32'(req_busy), 32'b00100);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_active", 32'(active), 0);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_busy", 32'(req_busy), 0);
    chk("t5_rst_lba", sd_lba, 0);
    man_busy = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    set_lba(0, 32'h20);
    q.push_back(ex_issue(5'b00001, '0, 32'h20));
    req_rd = 5'b00101;
    wait_issue("t5_post_issue");
    man_busy = 1'b1;
    tick();
    req_rd = '0;
    q.push_back(ex_done(5'b00001, '0));
    man_done = 1'b1;
    tick();
    man_done = 1'b0; man_busy = 1'b0;
    wait_idle("t5_idle");

`ifdef SD_ARB_WATCHDOG_EN
    // 6: watchdog aborts a never-accepted request, next pending channel follows
    set_lba(1, 32'h21);
    q.push_back(ex_issue(5'b00010, '0, 32'h21)); q.push_back(ex_done(5'b00010, 5'b00010));
    q.push_back(ex_issue(5'b00001, '0, 32'h20)); q.push_back(ex_done(5'b00001, 5'b00001));
    req_rd = 5'b00011;
    wait_issue("t6_issue1");
    n = 0;
    while (req_done == '0 && n < 300) begin tick(); n++; end
    chk("t6_wdog_cycles1", 32'(n), 32'd100);
    chk("t6_sd_rd_drop", 32'(sd_rd), 0);
    wait_issue("t6_issue0");
    req_rd = '0;
    n = 0;
    while (req_done == '0 && n < 300) begin tick(); n++; end
    chk("t6_wdog_cycles0", 32'(n), 32'd100);
    wait_idle("t6_idle");
`endif

    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
